spi_shifter: RTL and testbench

- Byte-serial SPI master shift engine, directly downstream of the SPI controller's Wishbone register block.
- The controller latches a TX byte, mode and divider, and pulses start. The shifter generates SCK, drives MOSI, samples MISO and returns the RX byte with a done pulse.
- Chip selects stay in the controller; this block never touches them.
- Runs in the Wishbone clock domain.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_half_tick.sv | 44 ++++
 rtl/spi_shifter.sv | 153 +++++++++++++++
 tb/tb_spi_shifter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master shift engine.
package spi_pkg;

    localparam int SPI_BITS  = 8;
    localparam int SPI_EDGES = 2 * SPI_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } spi_state_t;

    // SPI mode: bit1 = CPOL (idle level of SCK), bit0 = CPHA (sampling phase)
    typedef logic [1:0] spi_mode_t;

    localparam spi_mode_t MODE0 = 2'b00;
    localparam spi_mode_t MODE1 = 2'b01;
    localparam spi_mode_t MODE2 = 2'b10;
    localparam spi_mode_t MODE3 = 2'b11;

endpackage

// File: rtl/spi_half_tick.sv
// Loadable down-counter that emits a one-cycle tick every D+1 cycles while
// enabled. The reload value is captured on load so the caller may change its
// divider input freely afterwards.
module spi_half_tick #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] reload_q, reload_d;
    logic                 at_zero;

    // Next count: load the divider, otherwise count down and reload on zero
    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        at_zero  = (cnt_q == '0);
        tick_o   = en_i && at_zero;
        if (load_i) begin
            cnt_d    = div_i;
            reload_d = div_i;
        end else if (en_i) begin
            cnt_d = at_zero ? reload_q : (cnt_q - DIV_WIDTH'(1));
        end
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end

endmodule

// File: rtl/spi_shifter.sv
// Byte-serial SPI master shift engine: generates SCK from a half-period
// divider, drives MOSI MSB first, samples MISO and returns the received byte
// with a one-cycle done pulse. Chip selects are handled elsewhere.
module spi_shifter
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_reset_i,
    input  logic                 start_i,
    input  logic [7:0]           tx_data_i,
    input  logic [1:0]           mode_i,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [7:0]           rx_data_o,
    output logic                 spi_clk_o,
    output logic                 spi_mosi_o,
    input  logic                 spi_miso_i
);

    localparam int EDGE_W = $clog2(SPI_EDGES);

    spi_state_t          state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [SPI_BITS-1:0] rx_data_q, rx_data_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                cpha_q, cpha_d;
    logic [SPI_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;

    logic                accept;
    logic                xfer_active;
    logic                tick;
    logic                leading;
    logic                sample_edge;
    logic                last_edge;
    logic [SPI_BITS-1:0] rx_next;

    assign xfer_active = (state_q == XFER);

    spi_half_tick #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_half_tick (
        .clk    (wb_clk_i),
        .reset  (wb_reset_i),
        .load_i (accept),
        .en_i   (xfer_active),
        .div_i  (clk_div_i),
        .tick_o (tick)
    );

    // Transfer sequencing: accept a request, toggle SCK on every tick, shift
    // MOSI on the launch edges and MISO on the sampling edges, finish on edge 16
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rx_data_d   = rx_data_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        cpha_d      = cpha_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        edge_cnt_d  = edge_cnt_q;
        accept      = 1'b0;
        leading     = ~edge_cnt_q[0];
        sample_edge = leading ^ cpha_q;
        last_edge   = (edge_cnt_q == EDGE_W'(SPI_EDGES - 1));
        rx_next     = sample_edge ? {rx_shift_q[SPI_BITS-2:0], spi_miso_i} : rx_shift_q;

        case (state_q)
            IDLE: begin
                sck_d  = mode_i[1];
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (start_i) begin
                    accept     = 1'b1;
                    state_d    = XFER;
                    busy_d     = 1'b1;
                    cpha_d     = mode_i[0];
                    rx_shift_d = '0;
                    edge_cnt_d = '0;
                    // CPHA=0 puts the MSB out immediately, so the shifter
                    // already holds the next bit for the first trailing edge
                    if (mode_i[0]) begin
                        tx_shift_d = tx_data_i;
                        mosi_d     = 1'b0;
                    end else begin
                        tx_shift_d = {tx_data_i[SPI_BITS-2:0], 1'b0};
                        mosi_d     = tx_data_i[SPI_BITS-1];
                    end
                end
            end
            XFER: begin
                if (tick) begin
                    sck_d      = ~sck_q;
                    edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                    rx_shift_d = rx_next;
                    if (last_edge) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        rx_data_d = rx_next;
                        mosi_d    = 1'b0;
                    end else if (leading == cpha_q) begin
                        mosi_d     = tx_shift_q[SPI_BITS-1];
                        tx_shift_d = {tx_shift_q[SPI_BITS-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, synchronous reset aborts any transfer
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cpha_q     <= cpha_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rx_data_o  = rx_data_q;
    assign spi_clk_o  = sck_q;
    assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_shifter.sv
// Self-checking bench for spi_shifter: a behavioural SPI slave answers the
// master, and each transfer is judged against timing and data rules derived
// directly from the SPI mode and divider.
module tb_spi_shifter;

    localparam int NUM_EDGES = 16;
    localparam int NUM_VECS  = 11;

    logic       wb_clk_i = 1'b0;
    logic       wb_reset_i;
    logic       start_i;
    logic [7:0] tx_data_i;
    logic [1:0] mode_i;
    logic [7:0] clk_div_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] rx_data_o;
    logic       spi_clk_o;
    logic       spi_mosi_o;
    logic       spi_miso_i;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [1:0] mode;
        int         div;
        logic [7:0] tx;
        logic [7:0] slave_byte;
        bit         loopback;
        int         glitch_cycle;
    } vec_t;

    vec_t vecs [NUM_VECS];

    // Slave configuration handed over at arm time, plus its live state
    bit         slave_arm       = 1'b0;
    logic [7:0] slave_next_byte = 8'h00;
    logic [1:0] slave_next_mode = 2'b00;
    bit         slave_next_loop = 1'b0;
    logic [7:0] slave_out       = 8'h00;
    logic [7:0] slave_rx        = 8'h00;
    bit         slave_cpol      = 1'b0;
    bit         slave_cpha      = 1'b0;
    bit         slave_loop      = 1'b0;
    logic       s_prev_sck      = 1'b0;
    logic       s_prev_mosi     = 1'b0;

    spi_shifter #(
        .DIV_WIDTH (8)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_reset_i (wb_reset_i),
        .start_i    (start_i),
        .tx_data_i  (tx_data_i),
        .mode_i     (mode_i),
        .clk_div_i  (clk_div_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rx_data_o  (rx_data_o),
        .spi_clk_o  (spi_clk_o),
        .spi_mosi_o (spi_mosi_o),
        .spi_miso_i (spi_miso_i)
    );

    // Free-running bus clock
    always #5 wb_clk_i = ~wb_clk_i;

    // Behavioural SPI slave: reacts to visible SCK edges mid-cycle, launching
    // its byte on the launch edges and capturing the MOSI level that was
    // stable just before each sampling edge
    initial begin
        logic lead;
        spi_miso_i = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (spi_clk_o !== s_prev_sck) begin
                lead = (spi_clk_o != slave_cpol);
                if (lead != slave_cpha) begin
                    slave_rx = {slave_rx[6:0], s_prev_mosi};
                end else if (slave_cpha) begin
                    spi_miso_i = slave_out[7];
                    slave_out  = {slave_out[6:0], 1'b0};
                end else begin
                    slave_out  = {slave_out[6:0], 1'b0};
                    spi_miso_i = slave_out[7];
                end
                s_prev_sck = spi_clk_o;
            end
            if (slave_arm) begin
                slave_arm  = 1'b0;
                slave_out  = slave_next_byte;
                slave_cpol = slave_next_mode[1];
                slave_cpha = slave_next_mode[0];
                slave_loop = slave_next_loop;
                slave_rx   = 8'h00;
                s_prev_sck = slave_next_mode[1];
                if (!slave_next_mode[0]) spi_miso_i = slave_next_byte[7];
            end
            if (slave_loop) spi_miso_i = spi_mosi_o;
            s_prev_mosi = spi_mosi_o;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference byte the master should receive for a vector
    function automatic int modelRx(input vec_t v);
        return v.loopback ? int'(v.tx) : int'(v.slave_byte);
    endfunction

    // Drives one transfer starting in the current cycle and checks it up to
    // and including the done cycle; returns mid done cycle so a back-to-back
    // start can be driven immediately
    task automatic applyStimulus(input vec_t v, input int idx);
        int   d;
        int   cyc;
        int   limit;
        int   edges;
        int   busy_cycles;
        int   done_cyc;
        int   timing_err;
        int   parity_err;
        int   mosi_high;
        logic prev_sck;
        logic cpol;

        d               = v.div;
        cpol            = v.mode[1];
        tx_data_i       = v.tx;
        mode_i          = v.mode;
        clk_div_i       = 8'(v.div);
        slave_next_byte = v.slave_byte;
        slave_next_mode = v.mode;
        slave_next_loop = v.loopback;
        slave_arm       = 1'b1;
        start_i         = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        start_i = 1'b0;
        cyc     = 1;
        checkOutput($sformatf("v%0d cycle1 busy", idx), int'(busy_o), 1);
        checkOutput($sformatf("v%0d cycle1 sck", idx), int'(spi_clk_o), int'(cpol));

        prev_sck    = cpol;
        limit       = NUM_EDGES * (d + 1) + 8;
        edges       = 0;
        busy_cycles = 0;
        done_cyc    = -1;
        timing_err  = 0;
        parity_err  = 0;
        mosi_high   = 0;
        while (cyc <= limit && done_cyc < 0) begin
            if (v.glitch_cycle == cyc) begin
                start_i   = 1'b1;
                tx_data_i = 8'hFF;
            end else begin
                start_i = 1'b0;
            end
            if (spi_clk_o !== prev_sck) begin
                edges++;
                if (cyc != 1 + edges * (d + 1)) timing_err++;
                if ((edges % 2 == 1) != (spi_clk_o != cpol)) parity_err++;
                prev_sck = spi_clk_o;
            end
            if (busy_o) busy_cycles++;
            if (spi_mosi_o) mosi_high++;
            if (done_o) begin
                done_cyc = cyc;
            end else begin
                @(negedge wb_clk_i);
                cyc++;
            end
        end
        start_i = 1'b0;

        checkOutput($sformatf("v%0d done cycle", idx), done_cyc, 1 + NUM_EDGES * (d + 1));
        checkOutput($sformatf("v%0d busy cycles", idx), busy_cycles, NUM_EDGES * (d + 1));
        checkOutput($sformatf("v%0d sck edges", idx), edges, NUM_EDGES);
        checkOutput($sformatf("v%0d edge timing errors", idx), timing_err, 0);
        checkOutput($sformatf("v%0d edge direction errors", idx), parity_err, 0);
        checkOutput($sformatf("v%0d end sck", idx), int'(spi_clk_o), int'(cpol));
        checkOutput($sformatf("v%0d end mosi", idx), int'(spi_mosi_o), 0);
        checkOutput($sformatf("v%0d end busy", idx), int'(busy_o), 0);
        checkOutput($sformatf("v%0d rx data", idx), int'(rx_data_o), modelRx(v));
        if (v.glitch_cycle != 0) begin
            checkOutput($sformatf("v%0d mosi high cycles", idx), mosi_high, 0);
        end
        #2;
        checkOutput($sformatf("v%0d slave received", idx), int'(slave_rx), int'(v.tx));
    endtask

    // One idle cycle after a transfer: single done pulse, idle levels, rx held
    task automatic checkIdle(input vec_t v, input int idx);
        @(negedge wb_clk_i);
        checkOutput($sformatf("v%0d idle done", idx), int'(done_o), 0);
        checkOutput($sformatf("v%0d idle busy", idx), int'(busy_o), 0);
        checkOutput($sformatf("v%0d idle sck", idx), int'(spi_clk_o), int'(v.mode[1]));
        checkOutput($sformatf("v%0d idle mosi", idx), int'(spi_mosi_o), 0);
        checkOutput($sformatf("v%0d rx held", idx), int'(rx_data_o), modelRx(v));
    endtask

    // Main sequence: reset, table vectors, back-to-back max divider, abort
    initial begin
        vec_t va;
        vec_t vb;
        int   cyc;
        int   edges;
        int   dones;
        logic prev;

        wb_reset_i = 1'b1;
        start_i    = 1'b0;
        tx_data_i  = 8'h00;
        mode_i     = 2'b00;
        clk_div_i  = 8'h00;
        repeat (3) @(negedge wb_clk_i);
        checkOutput("reset busy", int'(busy_o), 0);
        checkOutput("reset done", int'(done_o), 0);
        checkOutput("reset rx", int'(rx_data_o), 0);
        checkOutput("reset sck", int'(spi_clk_o), 0);
        checkOutput("reset mosi", int'(spi_mosi_o), 0);
        wb_reset_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);

        vecs[0] = '{2'd0, 0, 8'hA5, 8'h00, 1'b1, 0};
        vecs[1] = '{2'd3, 3, 8'h3C, 8'hC3, 1'b0, 0};
        vecs[2] = '{2'd1, 1, 8'h81, 8'h7E, 1'b0, 0};
        vecs[3] = '{2'd2, 1, 8'h81, 8'h7E, 1'b0, 0};
        vecs[4] = '{2'd0, 2, 8'h00, 8'h5A, 1'b0, 5};
        for (int i = 5; i < NUM_VECS; i++) begin
            vecs[i].mode         = 2'($urandom_range(0, 3));
            vecs[i].div          = int'($urandom_range(0, 5));
            vecs[i].tx           = 8'($urandom);
            vecs[i].slave_byte   = 8'($urandom);
            vecs[i].loopback     = 1'($urandom_range(0, 1));
            vecs[i].glitch_cycle = 0;
        end

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], i);
            checkIdle(vecs[i], i);
        end

        va = '{2'd0, 255, 8'h96, 8'h5A, 1'b0, 0};
        vb = '{2'd0, 255, 8'h69, 8'h3C, 1'b0, 0};
        applyStimulus(va, 100);
        applyStimulus(vb, 101);
        checkIdle(vb, 101);

        @(negedge wb_clk_i);
        tx_data_i       = 8'hA5;
        mode_i          = 2'd0;
        clk_div_i       = 8'd1;
        slave_next_byte = 8'hFF;
        slave_next_mode = 2'd0;
        slave_next_loop = 1'b0;
        slave_arm       = 1'b1;
        start_i         = 1'b1;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        start_i = 1'b0;
        cyc     = 1;
        edges   = 0;
        prev    = 1'b0;
        while (edges < 7 && cyc < 200) begin
            @(negedge wb_clk_i);
            cyc++;
            if (spi_clk_o !== prev) begin
                edges++;
                prev = spi_clk_o;
            end
        end
        checkOutput("abort edge7 reached", edges, 7);
        checkOutput("abort edge7 cycle", cyc, 15);
        wb_reset_i = 1'b1;
        @(negedge wb_clk_i);
        checkOutput("abort busy", int'(busy_o), 0);
        checkOutput("abort sck", int'(spi_clk_o), 0);
        checkOutput("abort mosi", int'(spi_mosi_o), 0);
        checkOutput("abort rx", int'(rx_data_o), 0);
        checkOutput("abort done", int'(done_o), 0);
        @(negedge wb_clk_i);
        wb_reset_i = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge wb_clk_i);
            if (done_o) dones++;
        end
        checkOutput("abort no done pulse", dones, 0);
        checkOutput("abort stays idle", int'(busy_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
